// File: rtl/bru_pred_pkg.sv
// bru_pred_pkg: opcode/funct3 constants and the buffered micro-op layout shared by bru_pred and its FIFO
package bru_pred_pkg;
  localparam int XLEN_MAX = 64;
  localparam int ITAG_MAX = 8;
  localparam logic [4:0] OP_AUIPC = 5'b00101, OP_JAL = 5'b11011, OP_JALR = 5'b11001, OP_BRANCH = 5'b11000;
  localparam logic [2:0] F3_BEQ = 3'b000, F3_BNE = 3'b001, F3_BLT = 3'b100, F3_BGE = 3'b101, F3_BLTU = 3'b110, F3_BGEU = 3'b111;
  typedef struct packed {
    logic [XLEN_MAX-1:0] data1;
    logic [XLEN_MAX-1:0] data2;
    logic [XLEN_MAX-1:0] pc;
    logic [19:0]         imm20;
    logic [4:0]          opcode;
    logic [2:0]          funct3;
    logic                rvc;
    logic                pred_taken;
    logic [XLEN_MAX-1:0] pred_target;
    logic [ITAG_MAX-1:0] itag;
  } uop_t;
  function automatic logic is_cf(input logic [4:0] op);
    return op == OP_BRANCH || op == OP_JAL || op == OP_JALR;
  endfunction
endpackage

// File: rtl/bru_uop_fifo.sv
// bru_uop_fifo: DEPTH-entry uop FIFO (push/pop/clr in, head/full/empty out), extra pointer bit tells full from empty
module bru_uop_fifo import bru_pred_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic clr_i,
  input  logic push_i,
  input  logic pop_i,
  input  uop_t din_i,
  output uop_t dout_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);
  uop_t mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  assign empty_o = wp_q == rp_q;
  assign full_o = wp_q == {~rp_q[AW], rp_q[AW-1:0]};
  assign dout_o = mem_q[rp_q[AW-1:0]];
  always_comb begin
    wp_d = clr_i ? '0 : wp_q + (AW+1)'(push_i & !full_o);
    rp_d = clr_i ? '0 : rp_q + (AW+1)'(pop_i & !empty_o);
  end
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i & !full_o & !clr_i) mem_q[wp_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/bru_pred.sv
// bru_pred: branch resolution unit; buffers uops (in_*), resolves and checks prediction, registered result (out_*) and counters (cnt_*)
module bru_pred import bru_pred_pkg::*; #(
  parameter int XLEN   = 64,
  parameter int DEPTH  = 4,
  parameter int ITAG_W = 8,
  parameter int C_EXT  = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [XLEN-1:0]   in_data1_i,
  input  logic [XLEN-1:0]   in_data2_i,
  input  logic [XLEN-1:0]   in_pc_i,
  input  logic [19:0]       in_imm20_i,
  input  logic [4:0]        in_opcode_i,
  input  logic [2:0]        in_funct3_i,
  input  logic              in_rvc_i,
  input  logic              in_pred_taken_i,
  input  logic [XLEN-1:0]   in_pred_target_i,
  input  logic [ITAG_W-1:0] in_itag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [XLEN-1:0]   out_data_o,
  output logic              out_jump_o,
  output logic              out_redirect_o,
  output logic [XLEN-1:0]   out_redirect_pc_o,
  output logic              out_misalign_o,
  output logic [ITAG_W-1:0] out_itag_o,
  output logic [CNT_W-1:0]  cnt_branch_o,
  output logic [CNT_W-1:0]  cnt_mispred_o
);
  uop_t in_uop, h;
  logic full, empty, push, pop, load, hs;
  logic [XLEN-1:0] pc, d1, d2, off, pc_off, jsum, target, link, res_data, res_rpc;
  logic is_br, is_jal, is_jalr, is_auipc, cf, cond, jump, mis, redir;
  logic out_valid_q, out_valid_d, jump_q, jump_d, redir_q, redir_d, mis_q, mis_d, cf_q, cf_d;
  logic [XLEN-1:0] data_q, data_d, rpc_q, rpc_d;
  logic [ITAG_W-1:0] itag_q, itag_d;
  logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d, cnt_mispred_q, cnt_mispred_d;
  always_comb begin
    in_uop = '0;
    in_uop.data1 = XLEN_MAX'(in_data1_i);
    in_uop.data2 = XLEN_MAX'(in_data2_i);
    in_uop.pc = XLEN_MAX'(in_pc_i);
    in_uop.imm20 = in_imm20_i;
    in_uop.opcode = in_opcode_i;
    in_uop.funct3 = in_funct3_i;
    in_uop.rvc = in_rvc_i;
    in_uop.pred_taken = in_pred_taken_i;
    in_uop.pred_target = XLEN_MAX'(in_pred_target_i);
    in_uop.itag = ITAG_MAX'(in_itag_i);
  end
  assign push = in_valid_i & !full & !flush_i;
  assign load = !(out_valid_q & !out_ready_i);
  assign pop = load & !empty & !flush_i;
  assign hs = out_valid_q & out_ready_i;
  assign in_ready_o = !full;
  bru_uop_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i(clk_i), .arst_ni(arst_ni), .clr_i(flush_i), .push_i(push), .pop_i(pop),
    .din_i(in_uop), .dout_o(h), .full_o(full), .empty_o(empty)
  );
  // funct3[2:1] picks the comparison, funct3[0] inverts it (BNE/BGE/BGEU)
  always_comb begin
    pc = h.pc[XLEN-1:0];
    d1 = h.data1[XLEN-1:0];
    d2 = h.data2[XLEN-1:0];
    is_br = h.opcode == OP_BRANCH;
    is_jal = h.opcode == OP_JAL;
    is_jalr = h.opcode == OP_JALR;
    is_auipc = h.opcode == OP_AUIPC;
    cf = is_cf(h.opcode);
    off = is_auipc ? XLEN'($signed({h.imm20, 12'h000})) : is_jal ? XLEN'($signed({h.imm20, 1'b0})) :
          is_br ? XLEN'($signed({h.imm20[11:0], 1'b0})) : XLEN'($signed(h.imm20[11:0]));
    pc_off = pc + off;
    jsum = d1 + off;
    target = is_jalr ? {jsum[XLEN-1:1], 1'b0} : pc_off;
    link = pc + (h.rvc ? XLEN'(2) : XLEN'(4));
    cond = h.funct3[2:1] == 2'b00 ? (d1 == d2) ^ h.funct3[0] :
           h.funct3[2:1] == 2'b10 ? ($signed(d1) < $signed(d2)) ^ h.funct3[0] :
           h.funct3[2:1] == 2'b11 ? (d1 < d2) ^ h.funct3[0] : 1'b0;
    jump = is_jal | is_jalr | (is_br & cond);
    mis = jump & target[1] & (C_EXT == 0);
    redir = cf & !mis & ((jump != h.pred_taken) | (jump & (target != h.pred_target[XLEN-1:0])));
    res_data = is_auipc ? pc_off : (is_jal | is_jalr) ? link : '0;
    res_rpc = cf ? (jump ? target : link) : '0;
  end
  always_comb begin
    out_valid_d = flush_i ? 1'b0 : load ? !empty : out_valid_q;
    data_d = pop ? res_data : data_q;
    jump_d = pop ? jump : jump_q;
    redir_d = pop ? redir : redir_q;
    rpc_d = pop ? res_rpc : rpc_q;
    mis_d = pop ? mis : mis_q;
    cf_d = pop ? cf : cf_q;
    itag_d = pop ? h.itag[ITAG_W-1:0] : itag_q;
    cnt_branch_d = cnt_branch_q + CNT_W'(hs & cf_q);
    cnt_mispred_d = cnt_mispred_q + CNT_W'(hs & redir_q);
  end
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      out_valid_q <= 1'b0;
      data_q <= '0;
      jump_q <= 1'b0;
      redir_q <= 1'b0;
      rpc_q <= '0;
      mis_q <= 1'b0;
      cf_q <= 1'b0;
      itag_q <= '0;
      cnt_branch_q <= '0;
      cnt_mispred_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      data_q <= data_d;
      jump_q <= jump_d;
      redir_q <= redir_d;
      rpc_q <= rpc_d;
      mis_q <= mis_d;
      cf_q <= cf_d;
      itag_q <= itag_d;
      cnt_branch_q <= cnt_branch_d;
      cnt_mispred_q <= cnt_mispred_d;
    end
  end
  assign out_valid_o = out_valid_q;
  assign out_data_o = data_q;
  assign out_jump_o = jump_q;
  assign out_redirect_o = redir_q;
  assign out_redirect_pc_o = rpc_q;
  assign out_misalign_o = mis_q;
  assign out_itag_o = itag_q;
  assign cnt_branch_o = cnt_branch_q;
  assign cnt_mispred_o = cnt_mispred_q;
endmodule

// File: tb/tb_bru_pred.sv
// tb_bru_pred: directed self-checking bench for bru_pred (C_EXT=1 main instance, C_EXT=0 twin for misalignment)
module tb_bru_pred;
  localparam logic [4:0] OP_AUIPC = 5'b00101, OP_JAL = 5'b11011, OP_JALR = 5'b11001, OP_BRANCH = 5'b11000;
  logic clk, arst_ni, flush, in_valid, out_ready, rvc, pred_taken;
  logic [63:0] d1, d2, pc, ptgt;
  logic [19:0] imm;
  logic [4:0] opc;
  logic [2:0] f3;
  logic [7:0] tag;
  logic in_ready_o, out_valid_o, out_jump_o, out_redirect_o, out_misalign_o;
  logic [63:0] out_data_o, out_redirect_pc_o;
  logic [7:0] out_itag_o;
  logic [31:0] cnt_branch_o, cnt_mispred_o;
  logic in_ready_1, out_valid_1, out_jump_1, out_redirect_1, out_misalign_1;
  logic [63:0] out_data_1, out_redirect_pc_1;
  logic [7:0] out_itag_1;
  logic [31:0] cnt_branch_1, cnt_mispred_1;
  int n_chk = 0, n_fail = 0, k;
  logic acc;
  bru_pred #(.XLEN(64), .DEPTH(4), .ITAG_W(8), .C_EXT(1), .CNT_W(32)) u_dut (
    .clk_i(clk), .arst_ni(arst_ni), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .in_data1_i(d1), .in_data2_i(d2), .in_pc_i(pc), .in_imm20_i(imm), .in_opcode_i(opc), .in_funct3_i(f3),
    .in_rvc_i(rvc), .in_pred_taken_i(pred_taken), .in_pred_target_i(ptgt), .in_itag_i(tag),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_data_o(out_data_o), .out_jump_o(out_jump_o),
    .out_redirect_o(out_redirect_o), .out_redirect_pc_o(out_redirect_pc_o), .out_misalign_o(out_misalign_o),
    .out_itag_o(out_itag_o), .cnt_branch_o(cnt_branch_o), .cnt_mispred_o(cnt_mispred_o)
  );
  bru_pred #(.XLEN(64), .DEPTH(4), .ITAG_W(8), .C_EXT(0), .CNT_W(32)) u_dut_nc (
    .clk_i(clk), .arst_ni(arst_ni), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready_1),
    .in_data1_i(d1), .in_data2_i(d2), .in_pc_i(pc), .in_imm20_i(imm), .in_opcode_i(opc), .in_funct3_i(f3),
    .in_rvc_i(rvc), .in_pred_taken_i(pred_taken), .in_pred_target_i(ptgt), .in_itag_i(tag),
    .out_valid_o(out_valid_1), .out_ready_i(out_ready), .out_data_o(out_data_1), .out_jump_o(out_jump_1),
    .out_redirect_o(out_redirect_1), .out_redirect_pc_o(out_redirect_pc_1), .out_misalign_o(out_misalign_1),
    .out_itag_o(out_itag_1), .cnt_branch_o(cnt_branch_1), .cnt_mispred_o(cnt_mispred_1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic set_op(input logic [4:0] o, input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] p, input logic [19:0] i, input logic r, input logic pt,
                        input logic [63:0] t, input logic [7:0] g);
    opc = o; f3 = f; d1 = a; d2 = b; pc = p; imm = i; rvc = r; pred_taken = pt; ptgt = t; tag = g;
  endtask
  task automatic run1();
    in_valid = 1;
    cycle();
    in_valid = 0;
    cycle();
  endtask
  initial begin
    clk = 0; arst_ni = 0; flush = 0; in_valid = 0; out_ready = 1;
    set_op(5'b0, 3'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_ready", in_ready_o, 1);
    chk("rst_cnt_br", cnt_branch_o, 0);
    chk("rst_cnt_mp", cnt_mispred_o, 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_rpc", out_redirect_pc_o, 0);
    arst_ni = 1;
    cycle();
    set_op(OP_BRANCH, 3'b000, 5, 5, 64'h1000, 20'h008, 0, 0, 0, 8'h01);
    run1();
    chk("beq_valid", out_valid_o, 1);
    chk("beq_jump", out_jump_o, 1);
    chk("beq_redir", out_redirect_o, 1);
    chk("beq_rpc", out_redirect_pc_o, 64'h1010);
    chk("beq_itag", out_itag_o, 8'h01);
    chk("beq_data", out_data_o, 0);
    cycle();
    chk("beq_cnt_mp", cnt_mispred_o, 1);
    chk("beq_cnt_br", cnt_branch_o, 1);
    chk("beq_drain", out_valid_o, 0);
    set_op(OP_BRANCH, 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h2000, 20'h008, 0, 1, 64'h2010, 8'h02);
    run1();
    chk("blt_jump", out_jump_o, 1);
    chk("blt_redir", out_redirect_o, 0);
    set_op(OP_BRANCH, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h2000, 20'h008, 0, 1, 64'h2010, 8'h03);
    run1();
    chk("bltu_jump", out_jump_o, 0);
    chk("bltu_redir", out_redirect_o, 1);
    chk("bltu_rpc", out_redirect_pc_o, 64'h2004);
    set_op(OP_BRANCH, 3'b001, 1, 2, 64'h2000, 20'h00FFF, 0, 1, 64'h1FFE, 8'h04);
    run1();
    chk("bne_jump", out_jump_o, 1);
    chk("bne_redir", out_redirect_o, 0);
    chk("bne_mis", out_misalign_o, 0);
    chk("bne_nc_mis", out_misalign_1, 1);
    chk("bne_nc_redir", out_redirect_1, 0);
    set_op(OP_JALR, 3'b000, 64'h3001, 0, 64'h100, 20'h002, 1, 1, 64'h3002, 8'h05);
    run1();
    chk("jalr_jump", out_jump_o, 1);
    chk("jalr_data", out_data_o, 64'h102);
    chk("jalr_rpc", out_redirect_pc_o, 64'h3002);
    chk("jalr_redir", out_redirect_o, 0);
    chk("jalr_mis", out_misalign_o, 0);
    chk("jalr_nc_mis", out_misalign_1, 1);
    chk("jalr_nc_redir", out_redirect_1, 0);
    set_op(OP_JAL, 3'b000, 0, 0, 64'h1000, 20'hFFFFF, 0, 0, 0, 8'h06);
    run1();
    chk("jal_jump", out_jump_o, 1);
    chk("jal_redir", out_redirect_o, 1);
    chk("jal_rpc", out_redirect_pc_o, 64'hFFE);
    chk("jal_data", out_data_o, 64'h1004);
    set_op(5'b00000, 3'b000, 0, 0, 64'h40, 20'h0, 0, 1, 64'h80, 8'h07);
    run1();
    chk("oth_jump", out_jump_o, 0);
    chk("oth_redir", out_redirect_o, 0);
    chk("oth_data", out_data_o, 0);
    cycle();
    chk("cnt_br_6", cnt_branch_o, 6);
    chk("cnt_mp_3", cnt_mispred_o, 3);
    out_ready = 0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      set_op(OP_AUIPC, 3'b0, 0, 0, 64'((k + 1) * 16), 20'(k + 1), 0, 0, 0, 8'(16 + k + 1));
      in_valid = k < 6;
      acc = in_valid && in_ready_o;
      if (out_valid_o) begin
        chk("stall_tag", out_itag_o, 8'h11);
        chk("stall_data", out_data_o, 64'h1010);
      end
      cycle();
      if (acc) k++;
    end
    chk("stall_accepted", k, 5);
    chk("stall_ready", in_ready_o, 0);
    in_valid = 0;
    out_ready = 1;
    for (int i = 1; i <= 5; i++) begin
      chk("rel_valid", out_valid_o, 1);
      chk("rel_tag", out_itag_o, 64'(16 + i));
      chk("rel_data", out_data_o, 64'(i * 16 + (i << 12)));
      cycle();
    end
    chk("rel_empty", out_valid_o, 0);
    chk("rel_cnt_br", cnt_branch_o, 6);
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_op(OP_JAL, 3'b0, 0, 0, 64'h500, 20'h1, 0, 0, 0, 8'(32 + i));
      in_valid = 1;
      cycle();
    end
    set_op(OP_JAL, 3'b0, 0, 0, 64'h500, 20'h1, 0, 0, 0, 8'h24);
    flush = 1;
    cycle();
    flush = 0;
    in_valid = 0;
    chk("flush_valid", out_valid_o, 0);
    chk("flush_ready", in_ready_o, 1);
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("flush_none", out_valid_o, 0);
    end
    chk("flush_cnt_br", cnt_branch_o, 6);
    chk("flush_cnt_mp", cnt_mispred_o, 3);
    set_op(OP_JAL, 3'b0, 0, 0, 64'h600, 20'h1, 0, 0, 0, 8'h30);
    run1();
    chk("fhs_valid", out_valid_o, 1);
    flush = 1;
    cycle();
    flush = 0;
    chk("fhs_gone", out_valid_o, 0);
    chk("fhs_cnt_br", cnt_branch_o, 7);
    chk("fhs_cnt_mp", cnt_mispred_o, 4);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) set_op(OP_AUIPC, 3'b0, 0, 0, 64'(4 * i), 20'hFFFFF, 0, 0, 0, 8'(64 + i));
      in_valid = i < 3;
      if (i >= 2) begin
        chk("b2b_valid", out_valid_o, 1);
        chk("b2b_tag", out_itag_o, 64'(64 + i - 2));
        chk("b2b_data", out_data_o, 64'hFFFF_FFFF_FFFF_F000 + 64'(4 * (i - 2)));
      end else chk("b2b_latency", out_valid_o, 0);
      cycle();
    end
    in_valid = 0;
    cycle();
    chk("b2b_done", out_valid_o, 0);
    chk("b2b_cnt_br", cnt_branch_o, 7);
    chk("b2b_cnt_mp", cnt_mispred_o, 4);
    set_op(OP_JAL, 3'b0, 0, 0, 64'h700, 20'h1, 0, 0, 0, 8'h50);
    run1();
    chk("ar_pre_valid", out_valid_o, 1);
    #2;
    arst_ni = 0;
    #1;
    chk("ar_valid", out_valid_o, 0);
    chk("ar_cnt_br", cnt_branch_o, 0);
    chk("ar_cnt_mp", cnt_mispred_o, 0);
    chk("ar_ready", in_ready_o, 1);
    chk("ar_data", out_data_o, 0);
    arst_ni = 1;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
